// File: rtl/data_mem.sv
// Word-addressed data memory: one store and one tagged, fixed-latency load per cycle.
// Optional macro DMEM_BYPASS_EN selects write-first for a same-edge store/load collision.
module data_mem #(
    parameter  int SIZE     = 32,
    parameter  int MEM_ROWS = 64,
    parameter  int ROB_ROWS = 16,
    parameter  int READ_LAT = 1,
    localparam int AW       = $clog2(MEM_ROWS),
    localparam int RW       = $clog2(ROB_ROWS),
    localparam int IW       = $clog2(READ_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EnWrite,
    input  logic [AW-1:0]   write_addr,
    input  logic [SIZE-1:0] write_data,
    input  logic            read_en,
    input  logic [AW-1:0]   read_addr,
    input  logic [RW-1:0]   in_robn,
    output logic [SIZE-1:0] read_data,
    output logic            read_valid,
    output logic [RW-1:0]   out_robn,
    output logic            wr_ack,
    output logic [IW-1:0]   inflight
);

    localparam int LAST = READ_LAT - 1;

    logic [SIZE-1:0] mem_q  [MEM_ROWS];
    logic            vld_q  [READ_LAT];
    logic [SIZE-1:0] data_q [READ_LAT];
    logic [RW-1:0]   robn_q [READ_LAT];
    logic            wr_ack_q;
    logic [IW-1:0]   inflight_q;
    logic [IW-1:0]   inflight_d;
    logic [SIZE-1:0] load_word;

    always_comb begin
        load_word = mem_q[read_addr];
`ifdef DMEM_BYPASS_EN
        if (EnWrite && (write_addr == read_addr)) begin
            load_word = write_data;
        end
`endif
    end

    // At most READ_LAT valid stages exist, so this never wraps.
    always_comb begin
        inflight_d = inflight_q + IW'(read_en) - IW'(vld_q[LAST]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_ROWS; i++) begin
                mem_q[i] <= '0;
            end
            for (int s = 0; s < READ_LAT; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                robn_q[s] <= '0;
            end
            wr_ack_q   <= 1'b0;
            inflight_q <= '0;
        end else begin
            if (EnWrite) begin
                mem_q[write_addr] <= write_data;
            end
            wr_ack_q <= EnWrite;

            // Payload only advances with a valid beat so the output holds its last result.
            vld_q[0] <= read_en;
            if (read_en) begin
                data_q[0] <= load_word;
                robn_q[0] <= in_robn;
            end
            for (int s = 1; s < READ_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                    robn_q[s] <= robn_q[s-1];
                end
            end

            inflight_q <= inflight_d;
        end
    end

    // read_valid qualifies read_data/out_robn for exactly one cycle; the consumer cannot stall it.
    assign read_valid = vld_q[LAST];
    assign read_data  = data_q[LAST];
    assign out_robn   = robn_q[LAST];
    assign wr_ack     = wr_ack_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: an array-based memory model queues expected load results,
// and a separate monitor checks them plus wr_ack, inflight and reset values.
module tb_data_mem;
  localparam int SIZE     = 32;
  localparam int MEM_ROWS = 64;
  localparam int ROB_ROWS = 16;
  localparam int READ_LAT = 3;
  localparam int AW       = $clog2(MEM_ROWS);
  localparam int RW       = $clog2(ROB_ROWS);
  localparam int IW       = $clog2(READ_LAT + 1);
  localparam int EW       = 32 + RW + SIZE;
`ifdef DMEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            EnWrite;
  logic [AW-1:0]   write_addr;
  logic [SIZE-1:0] write_data;
  logic            read_en;
  logic [AW-1:0]   read_addr;
  logic [RW-1:0]   in_robn;
  logic [SIZE-1:0] read_data;
  logic            read_valid;
  logic [RW-1:0]   out_robn;
  logic            wr_ack;
  logic [IW-1:0]   inflight;

  data_mem #(
    .SIZE(SIZE), .MEM_ROWS(MEM_ROWS), .ROB_ROWS(ROB_ROWS), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .EnWrite(EnWrite), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .in_robn(in_robn),
    .read_data(read_data), .read_valid(read_valid), .out_robn(out_robn),
    .wr_ack(wr_ack), .inflight(inflight)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [SIZE-1:0] ref_mem [MEM_ROWS];
  logic [EW-1:0]   exp_q[$];
  logic            exp_ack = 1'b0;
  int              cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_ROWS; i++) ref_mem[i] = '0;
      exp_ack = 1'b0;
    end else begin
      logic [SIZE-1:0] d;
      int due;
      cyc = cyc + 1;
      if (read_en) begin
        d = ref_mem[read_addr];
        if (BYPASS && EnWrite && write_addr == read_addr) d = write_data;
        due = cyc + READ_LAT - 1;
        exp_q.push_back({due[31:0], in_robn, d});
      end
      exp_ack = EnWrite;
      if (EnWrite) ref_mem[write_addr] = write_data;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int errors = 0;
  int checks = 0;
  int max_inflight = 0;
  logic [SIZE-1:0] last_data;
  logic [RW-1:0]   last_robn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_data = '0;
      last_robn = '0;
      chk("rst_read_valid", 64'(read_valid), 64'd0);
      chk("rst_read_data", 64'(read_data), 64'd0);
      chk("rst_out_robn", 64'(out_robn), 64'd0);
      chk("rst_wr_ack", 64'(wr_ack), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
    end else begin
      logic [EW-1:0] ent;
      int due;
      chk("wr_ack", 64'(wr_ack), 64'(exp_ack));
      chk("inflight", 64'(inflight), 64'(exp_q.size()));
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
      if (read_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(read_valid), 64'd0);
        end else begin
          ent = exp_q.pop_front();
          due = int'(ent[EW-1 -: 32]);
          chk("load_data", 64'(read_data), 64'(ent[SIZE-1:0]));
          chk("load_robn", 64'(out_robn), 64'(ent[SIZE +: RW]));
          chk("load_latency", 64'(cyc), 64'(due));
          last_data = ent[SIZE-1:0];
          last_robn = ent[SIZE +: RW];
        end
      end else begin
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
          ent = exp_q.pop_front();
          chk("missing_valid", 64'(read_valid), 64'd1);
        end
        chk("hold_data", 64'(read_data), 64'(last_data));
        chk("hold_robn", 64'(out_robn), 64'(last_robn));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [SIZE-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic [RW-1:0] rn);
    EnWrite = we; write_addr = wa; write_data = wd;
    read_en = re; read_addr = ra; in_robn = rn;
    @(posedge clk);
    #1;
    EnWrite = 1'b0;
    read_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    issue(1'b1, a, d, 1'b0, '0, '0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [RW-1:0] t);
    issue(1'b0, '0, '0, 1'b1, a, t);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    EnWrite = 1'b0; write_addr = '0; write_data = '0;
    read_en = 1'b0; read_addr = '0; in_robn = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    load(6'd5, 4'd3);
    idle(READ_LAT + 2);

    store(6'd10, 32'hDEADBEEF);
    load(6'd10, 4'd7);
    idle(READ_LAT + 2);

    store(6'd2, 32'h11);
    issue(1'b1, 6'd2, 32'h22, 1'b1, 6'd2, 4'd1);
    idle(READ_LAT + 2);

    for (int i = 0; i < 4; i++) store(AW'(i), SIZE'(i + 100));
    for (int i = 0; i < 4; i++) load(AW'(i), RW'(i));
    idle(READ_LAT + 2);
    chk("inflight_peak", 64'(max_inflight), 64'(READ_LAT));

    store(6'd4, 32'h55);
    load(6'd4, 4'd9);
    store(6'd4, 32'h66);
    idle(READ_LAT + 2);

    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), SIZE'($urandom()),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), RW'($urandom_range(0, ROB_ROWS - 1)));
    end
    idle(READ_LAT + 2);

    load(6'd10, 4'd1);
    load(6'd2, 4'd2);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(READ_LAT + 3);
    load(6'd10, 4'd5);
    idle(READ_LAT + 2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
